instr_fetch_queue: RTL
======================

# instr_fetch_queue

Instruction queue and issue sequencer for the video processor. It sits directly upstream of the video processor control unit: it buffers 32-bit instruction words written by the host and presents them one at a time on `opCode`/`data_out`. It retires each instruction using the control unit's `new_instruction` busy flag, so no instruction is lost or issued twice while the monitor is printing.

## Interface
- `DEPTH_LOG2`, 3: log2 of FIFO depth (default 8 entries).
- `ACK_TIMEOUT`, 4: cycles in ISSUE waiting for `cu_busy` to rise before the instruction is retired without acknowledge. Range 1..15.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host write strobe; one word per cycle.
- `instr_in`  in  32  instruction word: [3:0] opcode, [31:4] payload.
- `cu_busy`  in  1  control unit `new_instruction` (1 = busy, 0 = may accept).
- `opCode`  out  4  opcode presented to the control unit; 4'b1111 (NOP) when nothing is issued.
- `data_out`  out  28  payload of the issued instruction, to the register-bank input mux.
- `fifo_full`  out  1  FIFO holds 2^DEPTH_LOG2 words.
- `fifo_empty`  out  1  FIFO holds 0 words.
- `fifo_count`  out  DEPTH_LOG2+1  number of words in the FIFO; excludes the issued word.
- `overflow`  out  1  sticky; set when a write is dropped; cleared only by reset.
- `retire`  out  1  one-cycle pulse when the issued instruction is retired.

## Operation
- FIFO is a circular buffer with read/write pointers of width DEPTH_LOG2 and wrap-around at depth. `fifo_count` is an up/down counter.
- Write: on `wr_en` && !`fifo_full`, store `instr_in` and increment the count.
  - `wr_en` && `fifo_full` drops the word and sets `overflow`.
  - Full is evaluated before a same-cycle pop, so a write to a full FIFO is dropped even when a pop occurs in that cycle.
- FSM states:
  - IDLE: `opCode`=1111. If !`fifo_empty`, pop the head into the output register and go to ISSUE with the timeout counter at 0.
  - ISSUE: `opCode`/`data_out` hold the popped word.
    - If `cu_busy`=1, go to WAIT_DONE.
    - Else, once the counter reaches ACK_TIMEOUT-1, retire. This is the path for status opcode 0011 and for opcodes the control unit ignores.
    - Otherwise, increment the counter.
  - WAIT_DONE: hold outputs. When `cu_busy`=0, retire.
- Retire: pulse `retire`.
  - If the FIFO is non-empty, pop the next word in the same cycle and enter ISSUE with the counter at 0. Back-to-back issue has no NOP gap.
  - Otherwise drive `opCode`=1111 and go to IDLE.
- A pop and a write in the same cycle leave `fifo_count` unchanged.
- Pop on a non-empty FIFO is guaranteed; the FSM never pops when empty.
- Reset mid-operation: the FIFO contents and the in-flight instruction are discarded with no retire pulse.
- Reset values: `opCode`=4'b1111, `data_out`=0, `fifo_full`=0, `fifo_empty`=1, `fifo_count`=0, `overflow`=0, `retire`=0. State=IDLE, pointers=0.

## Timing
- All outputs are registered; state updates on posedge `clk`. `reset` is asynchronous assert, synchronous deassert (externally synchronized).
- Write-to-issue latency:
  - A word written at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1.
  - It is visible on `opCode` after edge N+1.
- `cu_busy` is sampled at each edge. A rise seen at the k-th ISSUE edge (k ≤ ACK_TIMEOUT) enters WAIT_DONE.
- Retire without acknowledge occurs at the ACK_TIMEOUT-th edge after entering ISSUE.
- `retire` is asserted for exactly the cycle following the retiring edge.

## Configuration
- `INSTR_OPCODE_FILTER_EN` defined:
  - A write whose opcode > 4'b0011 is not stored; it sets `overflow` and leaves `fifo_count` unchanged.
  - Illegal opcodes never reach the control unit.
- Undefined: every non-overflowing write is stored regardless of opcode. An illegal opcode is issued and then retired by timeout.

## Test plan
- Reset: hold `reset`=0 mid-WAIT_DONE with 3 words queued, then release. Required: `opCode`=1111, `fifo_count`=0, `fifo_empty`=1, `overflow`=0, no `retire` pulse.
- Single write: write 0x0000_1230 (opcode 0) at edge N, with `cu_busy` rising at N+2 and falling at N+5. Required: `opCode`=0000 and `data_out`=0x000_0123 from N+1; `retire` in the cycle after N+5; `opCode`=1111 afterwards.
- Timeout: write opcode 0011 with `cu_busy` held 0 and ACK_TIMEOUT=4. Required: retire at the 4th edge after issue, then IDLE.
- Back-to-back: queue 3 words; each acknowledged busy 1→0. Required: the next opcode is presented on the same edge as each `retire`, with no NOP gap; issue order equals write order.
- Full and overflow: write 9 words with `cu_busy`=1 held, giving 1 issued plus 8 queued. Then write when full and pop simultaneously. Required: `fifo_full`=1, the 10th word dropped, `overflow`=1 sticky, `fifo_count`=7 after the pop; pointers wrap correctly over 20 further writes.
- Filter: with `INSTR_OPCODE_FILTER_EN`, write opcode 0101. Required: not queued, `overflow`=1. Without the macro: issued, then retired after ACK_TIMEOUT.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: buffers 32-bit instruction words written by the host and
// issues them one at a time to the video processor control unit. Each issued
// instruction is retired when the control unit's busy flag falls. It is also
// retired without acknowledge if busy never rises within ACK_TIMEOUT cycles.
//
// Optional feature: define INSTR_OPCODE_FILTER_EN to drop writes whose opcode
// is above 4'b0011. A dropped write sets the sticky overflow flag.
//
// Parameters:
//   DEPTH_LOG2  - log2 of the FIFO depth
//   ACK_TIMEOUT - ISSUE cycles to wait for cu_busy before retiring (1..15)
// Ports:
//   clk, reset   - clock; asynchronous active-low reset
//   wr_en        - host write strobe, one word per cycle
//   instr_in     - instruction word: [3:0] opcode, [31:4] payload
//   cu_busy      - control unit new_instruction flag (1 = busy)
//   opCode       - issued opcode; 4'b1111 (NOP) when nothing is issued
//   data_out     - payload of the issued instruction
//   fifo_full    - FIFO holds 2^DEPTH_LOG2 words
//   fifo_empty   - FIFO holds no words
//   fifo_count   - queued words, excluding the issued one
//   overflow     - sticky flag for a dropped write
//   retire       - one-cycle pulse after the issued instruction retires
module instr_fetch_queue #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [31:0]           instr_in,
  input  logic                  cu_busy,
  output logic [3:0]            opCode,
  output logic [27:0]           data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  retire
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_FW = DEPTH_LOG2 + 1;
  localparam int unsigned TMO_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PAY_W  = 28;
  localparam logic [OP_W-1:0] NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  // FIFO storage and pointers
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WORD_W-1:0] head;

  // FSM
  state_t             state_q;
  state_t             state_d;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_d;
  logic [OP_W-1:0]    op_d;
  logic [PAY_W-1:0]   data_d;
  logic               retire_d;
  logic               retiring;
  logic               pop;

  // Write qualification
  logic               legal;
  logic               wr_accept;
  logic               wr_drop;
  logic [CNT_FW-1:0]  count_d;

`ifdef INSTR_OPCODE_FILTER_EN
  localparam logic [OP_W-1:0] MAX_LEGAL_OP = 4'b0011;
  assign legal = (instr_in[OP_W-1:0] <= MAX_LEGAL_OP);
`else
  assign legal = 1'b1;
`endif

  // Full is the registered flag, so a same-cycle pop never frees room for a write
  assign wr_accept = wr_en && !fifo_full && legal;
  assign wr_drop   = wr_en && !wr_accept;
  assign head      = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= instr_in;
    end
  end

  // Occupancy update from this cycle's push/pop pair
  always_comb begin
    count_d = fifo_count;
    case ({wr_accept, pop})
      2'b10:   count_d = fifo_count + CNT_FW'(1);
      2'b01:   count_d = fifo_count - CNT_FW'(1);
      default: count_d = fifo_count;
    endcase
  end

  // FIFO pointers, flags and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_d;
      fifo_full  <= (count_d == CNT_FW'(DEPTH));
      fifo_empty <= (count_d == '0);
      if (wr_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pop request and next output values
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    op_d     = opCode;
    data_d   = data_out;
    retire_d = 1'b0;
    retiring = 1'b0;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      ISSUE: begin
        if (cu_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          retiring = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!cu_busy) begin
          retiring = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = NOP;
      end
    endcase

    // Retiring chains straight into the next word when one is queued
    if (retiring) begin
      retire_d = 1'b1;
      if (!fifo_empty) begin
        pop = 1'b1;
      end else begin
        state_d = IDLE;
        op_d    = NOP;
      end
    end

    if (pop) begin
      state_d = ISSUE;
      tmo_d   = '0;
      op_d    = head[OP_W-1:0];
      data_d  = head[WORD_W-1:OP_W];
    end
  end

  // Registered issue outputs and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q    <= '0;
      opCode   <= NOP;
      data_out <= '0;
      retire   <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      opCode   <= op_d;
      data_out <= data_d;
      retire   <= retire_d;
    end
  end

endmodule
